// File: rtl/ram_sp_arb_pkg.sv
// ---------------------------------------------------------------------------
// ram_sp_arb_pkg
// Shared types and default constants for the two-requester single-port RAM
// arbiter (ram_sp_arbiter) and its round-robin sub-arbiter (rr_arb2).
// ---------------------------------------------------------------------------
package ram_sp_arb_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_RD_WAIT    = 1;

    // Controller sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        ACK  = 2'd3
    } state_t;

    // Index of a requester (0 or 1)
    typedef logic req_idx_t;

endpackage

// File: rtl/ram_sp_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2 : two-way arbiter with a last-grant register.
//
// Build option: RAM_SP_ARB_FIXED_PRIO_EN
//   undefined (default) : round-robin, on contention the requester that was
//                         not granted last wins.
//   defined             : fixed priority, requester 0 always wins contention.
//
// Ports
//   clk          in   system clock, rising edge
//   i_reset      in   synchronous active-high reset (last grant -> 1)
//   i_req[1:0]   in   request vector
//   i_advance    in   grant accepted this cycle; record it as last grant
//   o_grant[1:0] out  one-hot grant (combinational from i_req)
//   o_last_grant out  index of the most recently accepted grant
// ---------------------------------------------------------------------------
module rr_arb2
    import ram_sp_arb_pkg::*;
(
    input  logic       clk,
    input  logic       i_reset,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_grant,
    output req_idx_t   o_last_grant
);

    req_idx_t r_last_grant;

    always_comb begin
        o_grant = 2'b00;
`ifdef RAM_SP_ARB_FIXED_PRIO_EN
        if (i_req[0]) begin
            o_grant = 2'b01;
        end else if (i_req[1]) begin
            o_grant = 2'b10;
        end
`else
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            // Contention: whoever was not served last goes next
            2'b11:   o_grant = r_last_grant ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
`endif
    end

    // Tracks the most recent accepted grant in both modes; the top relies on
    // it to know which requester owns the transaction in flight.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_last_grant <= 1'b1;
        end else if (i_advance) begin
            r_last_grant <= o_grant[1];
        end
    end

    assign o_last_grant = r_last_grant;

endmodule

// File: rtl/ram_sp_arbiter.sv
// ---------------------------------------------------------------------------
// ram_sp_arbiter
// Shares one single-port RAM (address, bidirectional data, cs, we, oe)
// between two requesters. Requests are arbitrated by rr_arb2, the winner's
// address/direction/write data are latched at grant, and the RAM pins are
// sequenced: a write takes one WR cycle (ack in that cycle), a read holds
// cs/oe for RD_WAIT cycles, samples the bus on the last one and acks in ACK.
// Every transaction returns through IDLE, giving one turnaround cycle.
//
// Build option: RAM_SP_ARB_FIXED_PRIO_EN (see rr_arb2) selects fixed
// priority for requester 0 instead of round-robin.
//
// Ports
//   clk, reset               clock / synchronous active-high reset
//   reqN, weN, addrN, wdataN requester N request, direction (1=write),
//                            address, write data (N = 0, 1)
//   ackN                     one-cycle completion pulse for requester N
//   rdataN                   read data for requester N, valid with ackN
//   ram_address              RAM address (holds last value when idle)
//   ram_data                 RAM data bus, driven only in WR, else Z
//   ram_cs, ram_we, ram_oe   RAM chip select / write enable / output enable
// ---------------------------------------------------------------------------
module ram_sp_arbiter
    import ram_sp_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RD_WAIT    = DEF_RD_WAIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  ack0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [ADDR_WIDTH-1:0] ram_address,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe
);

    localparam int CNT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

    state_t                r_state;
    logic [CNT_W-1:0]      r_rd_cnt;
    logic                  r_ack0;
    logic                  r_ack1;
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1;
    logic [ADDR_WIDTH-1:0] r_ram_address;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_drive;
    logic                  r_ram_cs;
    logic                  r_ram_we;
    logic                  r_ram_oe;

    logic [1:0]            w_req;
    logic [1:0]            w_grant;
    logic                  w_advance;
    req_idx_t              w_gnt_idx;
    req_idx_t              w_last_grant;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

    assign w_req     = {req1, req0};
    // A grant is only taken while idle; requests seen in other states wait.
    assign w_advance = (r_state == IDLE) && (|w_grant);
    assign w_gnt_idx = w_grant[1];

    rr_arb2 u_arb (
        .clk          (clk),
        .i_reset      (reset),
        .i_req        (w_req),
        .i_advance    (w_advance),
        .o_grant      (w_grant),
        .o_last_grant (w_last_grant)
    );

    assign w_sel_we    = w_gnt_idx ? we1    : we0;
    assign w_sel_addr  = w_gnt_idx ? addr1  : addr0;
    assign w_sel_wdata = w_gnt_idx ? wdata1 : wdata0;

    // After a grant, w_last_grant names the owner of the transaction in
    // flight, so it steers the read-data capture and read ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_rd_cnt      <= '0;
            r_ack0        <= 1'b0;
            r_ack1        <= 1'b0;
            r_rdata0      <= '0;
            r_rdata1      <= '0;
            r_ram_address <= '0;
            r_wdata       <= '0;
            r_drive       <= 1'b0;
            r_ram_cs      <= 1'b0;
            r_ram_we      <= 1'b0;
            r_ram_oe      <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_advance) begin
                        r_ram_address <= w_sel_addr;
                        r_wdata       <= w_sel_wdata;
                        r_ram_cs      <= 1'b1;
                        if (w_sel_we) begin
                            // Write completes in the WR cycle itself
                            r_ram_we <= 1'b1;
                            r_drive  <= 1'b1;
                            r_ack0   <= ~w_gnt_idx;
                            r_ack1   <= w_gnt_idx;
                            r_state  <= WR;
                        end else begin
                            r_ram_oe <= 1'b1;
                            r_rd_cnt <= CNT_W'(RD_WAIT - 1);
                            r_state  <= RD;
                        end
                    end
                end
                WR: begin
                    r_ram_cs <= 1'b0;
                    r_ram_we <= 1'b0;
                    r_drive  <= 1'b0;
                    r_state  <= IDLE;
                end
                RD: begin
                    if (r_rd_cnt == '0) begin
                        if (w_last_grant) begin
                            r_rdata1 <= ram_data;
                            r_ack1   <= 1'b1;
                        end else begin
                            r_rdata0 <= ram_data;
                            r_ack0   <= 1'b1;
                        end
                        r_ram_cs <= 1'b0;
                        r_ram_oe <= 1'b0;
                        r_state  <= ACK;
                    end else begin
                        r_rd_cnt <= r_rd_cnt - 1'b1;
                    end
                end
                ACK: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ram_data    = r_drive ? r_wdata : {DATA_WIDTH{1'bz}};
    assign ram_address = r_ram_address;
    assign ram_cs      = r_ram_cs;
    assign ram_we      = r_ram_we;
    assign ram_oe      = r_ram_oe;
    assign ack0        = r_ack0;
    assign ack1        = r_ack1;
    assign rdata0      = r_rdata0;
    assign rdata1      = r_rdata1;

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_sp_arbiter : self-checking bench for ram_sp_arbiter (RD_WAIT = 3).
// A small RAM model sits on the pins; the expected behaviour comes from a
// transaction-level model (grant rule, per-transaction latency, expected
// memory contents) evaluated cycle by cycle.
// ---------------------------------------------------------------------------
module tb_ram_sp_arbiter;

    localparam int DW  = 8;
    localparam int AW  = 8;
    localparam int RDW = 3;

    typedef struct {
        bit          we;
        logic [7:0]  addr;
        logic [7:0]  data;
        int          gap;
    } txn_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] ram_address;
    tri1  [DW-1:0] ram_data;
    logic          ram_cs, ram_we, ram_oe;

    logic [DW-1:0] ram_mem [256] = '{default: 8'h00};
    logic [DW-1:0] ref_mem [256] = '{default: 8'h00};

    int            n_total = 0;
    int            n_bad   = 0;
    int            n_txn   = 0;
    bit            m_last;
    logic [DW-1:0] exp_rd0, exp_rd1;
    txn_t          q0[$];
    txn_t          q1[$];
    bit            order_q[$];

    always #5 clk = ~clk;

    ram_sp_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .RD_WAIT    (RDW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req0        (req0),
        .we0         (we0),
        .addr0       (addr0),
        .wdata0      (wdata0),
        .ack0        (ack0),
        .rdata0      (rdata0),
        .req1        (req1),
        .we1         (we1),
        .addr1       (addr1),
        .wdata1      (wdata1),
        .ack1        (ack1),
        .rdata1      (rdata1),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_cs      (ram_cs),
        .ram_we      (ram_we),
        .ram_oe      (ram_oe)
    );

    // Asynchronous-read, synchronous-write RAM on the shared pins
    assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_mem[ram_address] : {DW{1'bz}};
    always @(posedge clk) begin
        if (ram_cs && ram_we) ram_mem[ram_address] <= ram_data;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic txn_t mk(input bit we, input logic [7:0] addr,
                                input logic [7:0] data, input int gap);
        txn_t t;
        t.we = we; t.addr = addr; t.data = data; t.gap = gap;
        return t;
    endfunction

    task automatic model_reset();
        m_last  = 1'b1;
        exp_rd0 = '0;
        exp_rd1 = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_ack0",   32'(ack0), 0);
        chk("rst_ack1",   32'(ack1), 0);
        chk("rst_rdata0", 32'(rdata0), 0);
        chk("rst_rdata1", 32'(rdata1), 0);
        chk("rst_cs",     32'(ram_cs), 0);
        chk("rst_we",     32'(ram_we), 0);
        chk("rst_oe",     32'(ram_oe), 0);
        chk("rst_addr",   32'(ram_address), 0);
        chk("rst_bus_z",  32'(ram_data), 32'hFF);
        reset = 1'b0;
        model_reset();
    endtask

    // Drives both requesters from q0/q1 and checks every cycle against the
    // transaction model: grant rule, write ack 1 cycle / read ack RD_WAIT+1
    // cycles after the grant cycle, one idle cycle after every ack.
    task automatic run_txns(input int budget);
        int   cyc, free_at, ack_at, grant_at, gap0, gap1;
        bit   pend, who, r0, r1, e0, e1, e_cs, e_we, e_oe;
        txn_t cur;
        cyc = 0; free_at = 0; ack_at = 0; grant_at = 0;
        pend = 1'b0; who = 1'b0;
        cur  = mk(1'b0, 8'h00, 8'h00, 0);
        gap0 = (q0.size() > 0) ? q0[0].gap : 0;
        gap1 = (q1.size() > 0) ? q1[0].gap : 0;
        while (q0.size() > 0 || q1.size() > 0 || pend || cyc < free_at) begin
            r0 = (q0.size() > 0) && (gap0 == 0);
            r1 = (q1.size() > 0) && (gap1 == 0);
            req0 = r0;
            req1 = r1;
            // Once granted, the requester's fields are scrambled: the DUT
            // must be working from its latched copy.
            if (r0 && !(pend && !who)) begin
                we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].data;
            end else begin
                we0 = 1'($urandom_range(0, 1)); addr0 = 8'($urandom); wdata0 = 8'($urandom);
            end
            if (r1 && !(pend && who)) begin
                we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].data;
            end else begin
                we1 = 1'($urandom_range(0, 1)); addr1 = 8'($urandom); wdata1 = 8'($urandom);
            end
            if (!pend && cyc >= free_at && (r0 || r1)) begin
`ifdef RAM_SP_ARB_FIXED_PRIO_EN
                who = r0 ? 1'b0 : 1'b1;
`else
                who = (r0 && r1) ? !m_last : r1;
`endif
                m_last   = who;
                cur      = who ? q1[0] : q0[0];
                pend     = 1'b1;
                grant_at = cyc;
                ack_at   = cyc + (cur.we ? 1 : RDW + 1);
                free_at  = ack_at + 1;
            end
            @(posedge clk); cyc++; #1;
            e0   = pend && (cyc == ack_at) && !who;
            e1   = pend && (cyc == ack_at) && who;
            e_cs = pend && (cur.we ? (cyc == ack_at) : (cyc > grant_at && cyc < ack_at));
            e_we = e_cs && cur.we;
            e_oe = e_cs && !cur.we;
            if ((e0 || e1) && !cur.we) begin
                if (who) exp_rd1 = ref_mem[cur.addr];
                else     exp_rd0 = ref_mem[cur.addr];
            end
            chk("ack0",   32'(ack0),   32'(e0));
            chk("ack1",   32'(ack1),   32'(e1));
            chk("rdata0", 32'(rdata0), 32'(exp_rd0));
            chk("rdata1", 32'(rdata1), 32'(exp_rd1));
            chk("ram_cs", 32'(ram_cs), 32'(e_cs));
            chk("ram_we", 32'(ram_we), 32'(e_we));
            chk("ram_oe", 32'(ram_oe), 32'(e_oe));
            if (e_cs) chk("ram_address", 32'(ram_address), 32'(cur.addr));
            if (e_we)       chk("ram_data_wr", 32'(ram_data), 32'(cur.data));
            else if (!e_oe) chk("ram_data_z",  32'(ram_data), 32'hFF);
            if (q0.size() > 0 && !r0 && gap0 > 0) gap0--;
            if (q1.size() > 0 && !r1 && gap1 > 0) gap1--;
            if (e0 || e1) begin
                if (cur.we) ref_mem[cur.addr] = cur.data;
                n_txn++;
                $display("txn %0d: req%0d %s addr=0x%02h data=0x%02h grant@%0d ack@%0d",
                         n_txn, who, cur.we ? "WR" : "RD", cur.addr,
                         cur.we ? cur.data : (who ? exp_rd1 : exp_rd0), grant_at, ack_at);
                order_q.push_back(who);
                pend = 1'b0;
                if (who) begin
                    void'(q1.pop_front());
                    gap1 = (q1.size() > 0) ? q1[0].gap : 0;
                end else begin
                    void'(q0.pop_front());
                    gap0 = (q0.size() > 0) ? q0[0].gap : 0;
                end
            end
            if (cyc > budget) begin
                chk("timeout", 1, 0);
                q0.delete(); q1.delete();
                break;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    initial begin
        do_reset();

        // Requester 0 alone: write 0xA5 to 0x12, then read it back
        q0.push_back(mk(1'b1, 8'h12, 8'hA5, 0));
        q0.push_back(mk(1'b0, 8'h12, 8'h00, 0));
        run_txns(100);
        chk("readback_a5", 32'(rdata0), 32'hA5);

        // Contention straight out of reset: 4 writes from each side
        do_reset();
        order_q.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(1'b1, 8'h01, 8'($urandom), 0));
            q1.push_back(mk(1'b1, 8'h02, 8'($urandom), 0));
        end
        run_txns(200);
        chk("order_len", 32'(order_q.size()), 8);
        chk("first_grant", 32'(order_q[0]), 0);
`ifdef RAM_SP_ARB_FIXED_PRIO_EN
        chk("second_grant", 32'(order_q[1]), 0);
        chk("fifth_grant",  32'(order_q[4]), 1);
`else
        chk("second_grant", 32'(order_q[1]), 1);
        chk("third_grant",  32'(order_q[2]), 0);
`endif

        // Requester 1 holds its request across the ack
        q1.push_back(mk(1'b0, 8'h02, 8'h00, 0));
        q1.push_back(mk(1'b1, 8'h07, 8'h3C, 0));
        q1.push_back(mk(1'b0, 8'h07, 8'h00, 0));
        run_txns(100);
        chk("held_rd", 32'(rdata1), 32'h3C);

        // Randomized mix of reads/writes, small address space, random gaps
        for (int i = 0; i < 40; i++) begin
            q0.push_back(mk(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)),
                            8'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0));
            q1.push_back(mk(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)),
                            8'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0));
        end
        run_txns(2000);

        // Reset in the middle of a read
        q0.push_back(mk(1'b1, 8'h33, 8'h5C, 0));
        run_txns(50);
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h33; wdata0 = 8'h00;
        @(posedge clk); #1;
        chk("mid_rd_cs", 32'(ram_cs), 1);
        chk("mid_rd_oe", 32'(ram_oe), 1);
        @(posedge clk); #1;
        reset = 1'b1; req0 = 1'b0;
        @(posedge clk); #1;
        chk("abort_ack0",  32'(ack0), 0);
        chk("abort_cs",    32'(ram_cs), 0);
        chk("abort_oe",    32'(ram_oe), 0);
        chk("abort_we",    32'(ram_we), 0);
        chk("abort_bus_z", 32'(ram_data), 32'hFF);
        chk("abort_rd0",   32'(rdata0), 0);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("abort_no_ack0", 32'(ack0), 0);
            chk("abort_no_ack1", 32'(ack1), 0);
        end
        q0.push_back(mk(1'b0, 8'h33, 8'h00, 0));
        run_txns(50);
        chk("post_reset_rd", 32'(rdata0), 32'h5C);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
